// File: rtl/data_mem_responder_if.sv
// Data-port bus between the core (master) and the memory responder (slave).
interface data_mem_responder_if;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] dAddress;
   logic [31:0] dWriteData;
   logic [31:0] dReadData;
   logic        MemReady;
   logic        MemError;

   modport master (
      output MemRead, MemWrite, dAddress, dWriteData,
      input  dReadData, MemReady, MemError
   );

   modport slave (
      input  MemRead, MemWrite, dAddress, dWriteData,
      output dReadData, MemReady, MemError
   );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data RAM answering one core access at a time after a fixed
// number of wait states, with a one-cycle MemReady/MemError response strobe.
module data_mem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
   parameter int unsigned DEPTH_WORDS = 512,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   data_mem_responder_if.slave  dmem
);

   localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [32:0] BASE_EXT = {1'b0, BASE_ADDR};
   localparam logic [32:0] END_EXT  = BASE_EXT + 33'(4 * DEPTH_WORDS);
   localparam logic [3:0]  WS       = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      state_q, state_d;
   logic        armed_q, armed_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ready_q, ready_d;
   logic        error_q, error_d;

   logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};

   logic             req;
   logic             acc_err;
   logic             do_write;
   logic [31:0]      offset;
   logic [IDX_W-1:0] idx;

   assign req    = dmem.MemRead | dmem.MemWrite;
   assign offset = addr_q - BASE_ADDR;
   assign idx    = IDX_W'(offset >> 2);

   // Range check in 33 bits so a RAM placed near the top of memory cannot wrap.
   assign acc_err = (addr_q[1:0] != 2'b00)
                  | ({1'b0, addr_q} <  BASE_EXT)
                  | ({1'b0, addr_q} >= END_EXT)
                  | (rd_q & wr_q);

   always_comb begin
      state_d  = state_q;
      armed_d  = armed_q;
      cnt_d    = cnt_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      ready_d  = 1'b0;
      error_d  = 1'b0;
      do_write = 1'b0;

      if (!req) begin
         armed_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (armed_q && req) begin
               armed_d = 1'b0;
               rd_d    = dmem.MemRead;
               wr_d    = dmem.MemWrite;
               addr_d  = dmem.dAddress;
               wdata_d = dmem.dWriteData;
               cnt_d   = WS;
               state_d = S_WAIT;
            end
         end
         // Counter holds the remaining wait edges; zero means this edge enters RESP,
         // giving a response WAIT_STATES+1 edges after accept (also for zero waits).
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d  = S_RESP;
               ready_d  = 1'b1;
               error_d  = acc_err;
               do_write = wr_q & ~acc_err;
               if (acc_err) begin
                  rdata_d = '0;
               end else if (rd_q) begin
                  rdata_d = mem_q[idx];
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         armed_q <= 1'b1;
         cnt_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         armed_q <= armed_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         error_q <= error_d;
      end
   end

   // RAM contents survive reset; writes only occur while state_q is out of reset.
   always_ff @(posedge clk) begin
      if (do_write) begin
         mem_q[idx] <= wdata_q;
      end
   end

   assign dmem.dReadData = rdata_q;
   assign dmem.MemReady  = ready_q;
   assign dmem.MemError  = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_STATES=2 instance and a
// WAIT_STATES=0 instance on a shared clock and reset.
module tb_data_mem_responder;

   logic clk = 1'b0;
   logic rst;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   logic [31:0] exp_last [2];

   data_mem_responder_if bus2 ();
   data_mem_responder_if bus0 ();

   data_mem_responder #(
      .BASE_ADDR   (32'h1001_0000),
      .DEPTH_WORDS (512),
      .WAIT_STATES (2)
   ) u_ws2 (
      .clk  (clk),
      .rst  (rst),
      .dmem (bus2.slave)
   );

   data_mem_responder #(
      .BASE_ADDR   (32'h1001_0000),
      .DEPTH_WORDS (512),
      .WAIT_STATES (0)
   ) u_ws0 (
      .clk  (clk),
      .rst  (rst),
      .dmem (bus0.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int unsigned sel, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
      if (sel == 0) begin
         bus2.MemRead = rd; bus2.MemWrite = wr; bus2.dAddress = a; bus2.dWriteData = d;
      end else begin
         bus0.MemRead = rd; bus0.MemWrite = wr; bus0.dAddress = a; bus0.dWriteData = d;
      end
   endtask

   function automatic logic get_ready(input int unsigned sel);
      return (sel == 0) ? bus2.MemReady : bus0.MemReady;
   endfunction

   function automatic logic get_err(input int unsigned sel);
      return (sel == 0) ? bus2.MemError : bus0.MemError;
   endfunction

   function automatic logic [31:0] get_rdata(input int unsigned sel);
      return (sel == 0) ? bus2.dReadData : bus0.dReadData;
   endfunction

   // sel 0 -> WAIT_STATES=2 instance, sel 1 -> WAIT_STATES=0 instance.
   task automatic xfer(input string tag, input int unsigned sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic exp_err, input logic [31:0] exp_rd);
      int unsigned ws;
      ws = (sel == 0) ? 2 : 0;
      drive(sel, rd, wr, a, d);
      for (int i = 0; i <= int'(ws); i++) begin
         tick();
         check({tag, "_early"}, {31'd0, get_ready(sel)}, 32'd0);
      end
      tick();
      if (exp_err) exp_last[sel] = '0;
      else if (rd) exp_last[sel] = exp_rd;
      check({tag, "_ready"}, {31'd0, get_ready(sel)}, 32'd1);
      check({tag, "_err"},   {31'd0, get_err(sel)},   {31'd0, exp_err});
      check({tag, "_rdata"}, get_rdata(sel), exp_last[sel]);
      drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      check({tag, "_drop"}, {31'd0, get_ready(sel)}, 32'd0);
   endtask

   initial begin
      int unsigned pulses;
      exp_last[0] = '0;
      exp_last[1] = '0;
      rst = 1'b1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();
      check("rst_ready2", {31'd0, bus2.MemReady}, 32'd0);
      check("rst_err2",   {31'd0, bus2.MemError}, 32'd0);
      check("rst_rdata2", bus2.dReadData, 32'd0);
      check("rst_ready0", {31'd0, bus0.MemReady}, 32'd0);
      check("rst_rdata0", bus0.dReadData, 32'd0);
      rst = 1'b0;
      tick();

      // Write/read and error cases on the two-wait-state instance.
      xfer("wr_beef",   0, 1'b0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 1'b0, 32'h0);
      xfer("rd_beef",   0, 1'b1, 1'b0, 32'h1001_0004, 32'h0,         1'b0, 32'hDEAD_BEEF);
      xfer("wr_w0",     0, 1'b0, 1'b1, 32'h1001_0000, 32'h1111_2222, 1'b0, 32'h0);
      xfer("wr_mis",    0, 1'b0, 1'b1, 32'h1001_0002, 32'h1234_5678, 1'b1, 32'h0);
      xfer("rd_w0",     0, 1'b1, 1'b0, 32'h1001_0000, 32'h0,         1'b0, 32'h1111_2222);
      xfer("rd_hi_oor", 0, 1'b1, 1'b0, 32'h1001_0800, 32'h0,         1'b1, 32'h0);
      xfer("rd_beef2",  0, 1'b1, 1'b0, 32'h1001_0004, 32'h0,         1'b0, 32'hDEAD_BEEF);
      xfer("rd_lo_oor", 0, 1'b1, 1'b0, 32'h1000_FFFC, 32'h0,         1'b1, 32'h0);
      xfer("wr_last",   0, 1'b0, 1'b1, 32'h1001_07FC, 32'h55AA_55AA, 1'b0, 32'h0);
      xfer("rd_last",   0, 1'b1, 1'b0, 32'h1001_07FC, 32'h0,         1'b0, 32'h55AA_55AA);
      xfer("conflict",  0, 1'b1, 1'b1, 32'h1001_0004, 32'h9999_9999, 1'b1, 32'h0);
      xfer("rd_beef3",  0, 1'b1, 1'b0, 32'h1001_0004, 32'h0,         1'b0, 32'hDEAD_BEEF);

      // A read held high for ten cycles is serviced once.
      pulses = 0;
      drive(0, 1'b1, 1'b0, 32'h1001_07FC, 32'h0);
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus2.MemReady) pulses++;
      end
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         if (bus2.MemReady) pulses++;
      end
      check("hold_pulses", pulses, 32'd1);
      check("hold_rdata", bus2.dReadData, 32'h55AA_55AA);

      // Zero-wait instance: response one edge after accept, one access per 3 cycles.
      xfer("z_wr8",  1, 1'b0, 1'b1, 32'h1001_0008, 32'h0102_0304, 1'b0, 32'h0);
      xfer("z_rd8",  1, 1'b1, 1'b0, 32'h1001_0008, 32'h0,         1'b0, 32'h0102_0304);
      xfer("z_wrC",  1, 1'b0, 1'b1, 32'h1001_000C, 32'hA0B0_C0D0, 1'b0, 32'h0);
      xfer("z_rdC",  1, 1'b1, 1'b0, 32'h1001_000C, 32'h0,         1'b0, 32'hA0B0_C0D0);
      xfer("z_oor",  1, 1'b1, 1'b0, 32'h1002_0000, 32'h0,         1'b1, 32'h0);
      xfer("z_rd8b", 1, 1'b1, 1'b0, 32'h1001_0008, 32'h0,         1'b0, 32'h0102_0304);

      // Reset while MemReady is high clears outputs asynchronously.
      drive(0, 1'b1, 1'b0, 32'h1001_0004, 32'h0);
      for (int i = 0; i < 4; i++) tick();
      check("rresp_ready", {31'd0, bus2.MemReady}, 32'd1);
      check("rresp_rdata", bus2.dReadData, 32'hDEAD_BEEF);
      rst = 1'b1;
      #1;
      check("rresp_rst_ready", {31'd0, bus2.MemReady}, 32'd0);
      check("rresp_rst_rdata", bus2.dReadData, 32'd0);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      rst = 1'b0;
      exp_last[0] = '0;
      exp_last[1] = '0;
      tick();

      // Reset during WAIT discards the pending write.
      drive(0, 1'b0, 1'b1, 32'h1001_0010, 32'hCAFE_F00D);
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("rwait_ready", {31'd0, bus2.MemReady}, 32'd0);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      rst = 1'b0;
      tick();
      xfer("rd_after_rst", 0, 1'b1, 1'b0, 32'h1001_0010, 32'h0, 1'b0, 32'h0);
      xfer("rd_beef_rst",  0, 1'b1, 1'b0, 32'h1001_0004, 32'h0, 1'b0, 32'hDEAD_BEEF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
